// File: rtl/gd_update_sequencer.sv
// Initiator for the gradient_descent update interface: streams weight/gradient
// pairs from two synchronous read ports into gradient_descent, collects each
// W_updated/done response and writes it back to weight memory at its address.
module gd_update_sequencer #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned ADDR_W          = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [ADDR_W:0]   len_in,
   input  logic [WIDTH-1:0]  lr_in,
   output logic              rd_en_out,
   output logic [ADDR_W-1:0] rd_addr_out,
   input  logic [WIDTH-1:0]  w_rd_data_in,
   input  logic [WIDTH-1:0]  g_rd_data_in,
   output logic [WIDTH-1:0]  gd_lr_out,
   output logic [WIDTH-1:0]  gd_w_old_out,
   output logic [WIDTH-1:0]  gd_grad_out,
   output logic              gd_valid_out,
   input  logic [WIDTH-1:0]  gd_w_updated_in,
   input  logic              gd_done_in,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [WIDTH-1:0]  wr_data_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              err_out
);

   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q;
   logic [WIDTH-1:0]    lr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CntW-1:0]     outst_q, outst_d;
   logic                rd_v1_q;
   logic [ADDR_W-1:0]   tag1_q;
   logic                gd_valid_q;
   logic [WIDTH-1:0]    gd_w_old_q, gd_grad_q;
   logic [ADDR_W-1:0]   tag_mem [MAX_OUTSTANDING];
   logic [PtrW-1:0]     wptr_q, rptr_q;
   logic [CntW-1:0]     cnt_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [WIDTH-1:0]    wr_data_q;
   logic                err_q;

   logic                rd_en, last_rd, start_ok, push, pop;
   logic [ADDR_W:0]     len_clamped;

   // Read issue, throttling and handshake decode
   always_comb begin
      start_ok    = (state_q == StIdle) && start_in;
      len_clamped = (len_in > MaxLen) ? MaxLen : len_in;
      rd_en       = (state_q == StRun) && (outst_q < CntW'(MAX_OUTSTANDING));
      last_rd     = rd_en && ({1'b0, addr_q} == (len_q - 1'b1));
      push        = rd_v1_q;
      // A response only counts when a tag is waiting for it
      pop         = gd_done_in && (cnt_q != '0);
      outst_d     = outst_q + CntW'(rd_en) - CntW'(pop);
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_in) state_d = (len_clamped != '0) ? StRun : StDone;
         StRun:   if (last_rd) state_d = StDrain;
         StDrain: if (outst_q == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Pass control: latched parameters, read address, outstanding count, error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         lr_q    <= '0;
         addr_q  <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         if (start_ok) begin
            len_q  <= len_clamped;
            lr_q   <= lr_in;
            addr_q <= '0;
         end else if (rd_en && !last_rd) begin
            addr_q <= addr_q + 1'b1;
         end
         if (start_ok)                        err_q <= 1'b0;
         else if (gd_done_in && cnt_q == '0)  err_q <= 1'b1;
      end
   end

   // Read data pipeline into gradient_descent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v1_q    <= 1'b0;
         tag1_q     <= '0;
         gd_valid_q <= 1'b0;
         gd_w_old_q <= '0;
         gd_grad_q  <= '0;
      end else begin
         rd_v1_q    <= rd_en;
         tag1_q     <= addr_q;
         gd_valid_q <= rd_v1_q;
         if (rd_v1_q) begin
            gd_w_old_q <= w_rd_data_in;
            gd_grad_q  <= g_rd_data_in;
         end
      end
   end

   // Tag FIFO: addresses of issued updates awaiting their response, in issue order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tag_mem[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            tag_mem[wptr_q] <= tag1_q;
            wptr_q <= (wptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
         end
         if (pop) rptr_q <= (rptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
         cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   // Write-back of each accepted response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= pop;
         if (pop) begin
            wr_addr_q <= tag_mem[rptr_q];
            wr_data_q <= gd_w_updated_in;
         end
      end
   end

   // Output drive
   always_comb begin
      rd_en_out    = rd_en;
      rd_addr_out  = addr_q;
      gd_lr_out    = lr_q;
      gd_w_old_out = gd_w_old_q;
      gd_grad_out  = gd_grad_q;
      gd_valid_out = gd_valid_q;
      wr_en_out    = wr_en_q;
      wr_addr_out  = wr_addr_q;
      wr_data_out  = wr_data_q;
      busy_out     = (state_q == StRun) || (state_q == StDrain);
      done_out     = (state_q == StDone);
      err_out      = err_q;
   end

endmodule

// File: tb/tb_gd_update_sequencer.sv
// Bench for gd_update_sequencer: memory and gradient_descent models around the
// DUT, a per-cycle compare process and directed passes with literal timings.
module tb_gd_update_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_in = 1'b0;
   logic [4:0]  len_in = '0;
   logic [15:0] lr_in = '0;
   logic        rd_en_out;
   logic [3:0]  rd_addr_out;
   logic [15:0] w_rd_data_in = '0, g_rd_data_in = '0;
   logic [15:0] gd_lr_out, gd_w_old_out, gd_grad_out;
   logic        gd_valid_out;
   logic [15:0] gd_w_updated_in = '0;
   logic        gd_done_in = 1'b0;
   logic        wr_en_out;
   logic [3:0]  wr_addr_out;
   logic [15:0] wr_data_out;
   logic        busy_out, done_out, err_out;

   gd_update_sequencer dut (
      .clk(clk), .rst(rst), .start_in(start_in), .len_in(len_in), .lr_in(lr_in),
      .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
      .w_rd_data_in(w_rd_data_in), .g_rd_data_in(g_rd_data_in),
      .gd_lr_out(gd_lr_out), .gd_w_old_out(gd_w_old_out), .gd_grad_out(gd_grad_out),
      .gd_valid_out(gd_valid_out), .gd_w_updated_in(gd_w_updated_in),
      .gd_done_in(gd_done_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .busy_out(busy_out), .done_out(done_out),
      .err_out(err_out)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int gcyc = 0, start_cyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Q8.8 gradient step used by the gradient_descent stand-in
   function automatic logic [15:0] gd_fn(input logic [15:0] w, input logic [15:0] lr,
                                         input logic [15:0] g);
      logic [31:0] p;
      p = lr * g;
      return w - p[23:8];
   endfunction

   // Environment: memories and gradient_descent model
   logic [15:0] wmem [16], gmem [16];
   logic        pv [16];
   logic [15:0] pd [16];
   int          gd_lat = 1;
   logic        stray_req = 1'b0, flush_req = 1'b0;

   initial begin
      logic s_rd, s_v, s_wr;
      logic [3:0] s_addr, s_wa;
      logic [15:0] s_w, s_g, s_lr, s_wd;
      for (int i = 0; i < 16; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      forever begin
         @(negedge clk);
         s_rd = rd_en_out; s_addr = rd_addr_out; s_v = gd_valid_out;
         s_w = gd_w_old_out; s_g = gd_grad_out; s_lr = gd_lr_out;
         s_wr = wr_en_out; s_wa = wr_addr_out; s_wd = wr_data_out;
         @(posedge clk);
         #1;
         if (s_rd) begin w_rd_data_in = wmem[s_addr]; g_rd_data_in = gmem[s_addr]; end
         if (s_wr) wmem[s_wa] = s_wd;
         for (int i = 15; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
         pv[0] = s_v;
         pd[0] = gd_fn(s_w, s_lr, s_g);
         if (flush_req) begin
            for (int i = 0; i < 16; i++) pv[i] = 1'b0;
            flush_req = 1'b0;
         end
         gd_done_in = pv[gd_lat-1] | stray_req;
         gd_w_updated_in = pd[gd_lat-1];
         stray_req = 1'b0;
      end
   end

   // Reference model of one pass: reads and gd issues in address order, writes
   // in address order carrying gd_fn of the original pair.
   logic [15:0] w_snap [16], g_snap [16], exp_w [16];
   int m_len, m_rd_idx, m_v_idx, m_wr_idx, m_outst, max_outst;
   logic [15:0] m_lr;
   int n_rd, n_wr, n_v, n_busy, n_done;
   int t_first_rd, t_last_rd, t_first_wr, t_last_wr, t_done, t_busy;

   task automatic begin_pass(input int len, input logic [15:0] lr);
      m_len = (len > 16) ? 16 : len;
      m_lr = lr;
      for (int i = 0; i < 16; i++) begin
         w_snap[i] = wmem[i];
         g_snap[i] = gmem[i];
         exp_w[i] = gd_fn(wmem[i], lr, gmem[i]);
      end
      m_rd_idx = 0; m_v_idx = 0; m_wr_idx = 0; m_outst = 0; max_outst = 0;
      n_rd = 0; n_wr = 0; n_v = 0; n_busy = 0; n_done = 0;
      t_first_rd = -1; t_last_rd = -1; t_first_wr = -1; t_last_wr = -1;
      t_done = -1; t_busy = -1;
   endtask

   // Compare process
   initial begin
      int rel;
      forever begin
         @(negedge clk);
         rel = gcyc - start_cyc;
         if (!rst) begin
            if (busy_out) begin
               n_busy++;
               if (t_busy < 0) t_busy = rel;
            end
            if (rd_en_out) begin
               chk("rd_addr", 32'(rd_addr_out), 32'(m_rd_idx));
               chk("rd_throttle", 32'(m_outst < 4), 32'd1);
               chk("rd_in_pass", 32'(busy_out), 32'd1);
               m_rd_idx++; m_outst++; n_rd++;
               if (t_first_rd < 0) t_first_rd = rel;
               t_last_rd = rel;
            end
            if (gd_valid_out) begin
               chk("gd_w_old", 32'(gd_w_old_out), 32'(w_snap[m_v_idx % 16]));
               chk("gd_grad", 32'(gd_grad_out), 32'(g_snap[m_v_idx % 16]));
               chk("gd_lr", 32'(gd_lr_out), 32'(m_lr));
               m_v_idx++; n_v++;
            end
            if (gd_done_in && m_outst > 0) m_outst--;
            if (m_outst > max_outst) max_outst = m_outst;
            if (wr_en_out) begin
               chk("wr_addr", 32'(wr_addr_out), 32'(m_wr_idx));
               chk("wr_data", 32'(wr_data_out), 32'(exp_w[m_wr_idx % 16]));
               m_wr_idx++; n_wr++;
               if (t_first_wr < 0) t_first_wr = rel;
               t_last_wr = rel;
            end
            if (done_out) begin
               chk("done_wr_count", 32'(m_wr_idx), 32'(m_len));
               n_done++;
               t_done = rel;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // Drive cycle 0 of a pass; returns in cycle 1 with start dropped unless held
   task automatic launch(input logic [4:0] len, input logic [15:0] lr, input bit hold);
      begin_pass(int'(len), lr);
      start_cyc = gcyc;
      start_in = 1'b1; len_in = len; lr_in = lr;
      tick(1);
      if (!hold) start_in = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (t_done < 0 && n < budget) begin tick(1); n++; end
      if (t_done < 0) chk("done_timeout", 32'd0, 32'd1);
      tick(2);
   endtask

   task automatic fill(input int seed);
      for (int i = 0; i < 16; i++) begin
         wmem[i] = 16'(i * 16'h0111 + seed);
         gmem[i] = 16'(seed * 3 + i * 16'h0023);
      end
   endtask

   initial begin
      fill(5);
      tick(3);
      chk("reset_outs", 32'({rd_en_out, gd_valid_out, wr_en_out, busy_out, done_out, err_out,
                            rd_addr_out, wr_addr_out}), 32'd0);
      chk("reset_data", 32'({gd_lr_out, gd_w_old_out}) | 32'({gd_grad_out, wr_data_out}),
          32'd0);
      rst = 1'b0;
      tick(2);

      // len 4, 1-cycle GD: reads 1-4, writes 5-8, done 9
      for (int i = 0; i < 16; i++) begin wmem[i] = 16'(16'h0100 * (i + 1)); gmem[i] = 16'h0200; end
      gd_lat = 1;
      launch(5'd4, 16'h0080, 1'b0);
      wait_done(50);
      chk("t1_first_rd", 32'(t_first_rd), 32'd1);
      chk("t1_last_rd", 32'(t_last_rd), 32'd4);
      chk("t1_first_wr", 32'(t_first_wr), 32'd5);
      chk("t1_last_wr", 32'(t_last_wr), 32'd8);
      chk("t1_done", 32'(t_done), 32'd9);
      chk("t1_busy_start", 32'(t_busy), 32'd1);
      chk("t1_busy_cycles", 32'(n_busy), 32'd8);
      chk("t1_w0", 32'(wmem[0]), 32'h0000);
      chk("t1_w1", 32'(wmem[1]), 32'h0100);
      chk("t1_w2", 32'(wmem[2]), 32'h0200);
      chk("t1_w3", 32'(wmem[3]), 32'h0300);
      chk("t1_w4_untouched", 32'(wmem[4]), 32'h0500);

      // len 16, 6-cycle GD: throttled at 4 outstanding
      fill(9);
      gd_lat = 6;
      launch(5'd16, 16'h0040, 1'b0);
      wait_done(300);
      chk("t2_writes", 32'(n_wr), 32'd16);
      chk("t2_reads", 32'(n_rd), 32'd16);
      chk("t2_max_outst", 32'(max_outst), 32'd4);
      chk("t2_err", 32'(err_out), 32'd0);

      // len 31 clamps to 16, no stalls: done at 21
      fill(2);
      gd_lat = 1;
      launch(5'd31, 16'h0100, 1'b0);
      wait_done(100);
      chk("t3_writes", 32'(n_wr), 32'd16);
      chk("t3_done", 32'(t_done), 32'd21);

      // len 0: done pulse at cycle 1, no traffic
      launch(5'd0, 16'h1234, 1'b0);
      wait_done(20);
      tick(5);
      chk("t4_done", 32'(t_done), 32'd1);
      chk("t4_activity", 32'(n_rd + n_wr + n_v + n_busy), 32'd0);
      chk("t4_done_count", 32'(n_done), 32'd1);

      // start held through the pass and its done cycle: exactly one pass
      fill(7);
      launch(5'd3, 16'h0055, 1'b1);
      tick(8);
      start_in = 1'b0;
      tick(12);
      chk("t5_done_count", 32'(n_done), 32'd1);
      chk("t5_done", 32'(t_done), 32'd8);
      chk("t5_reads", 32'(n_rd), 32'd3);

      // reset after two reads, then a stray done, then a clean pass
      fill(3);
      launch(5'd8, 16'h0090, 1'b0);
      tick(2);
      rst = 1'b1;
      flush_req = 1'b1;
      #1;
      chk("t6_rst_outs", 32'({rd_en_out, gd_valid_out, wr_en_out, busy_out, done_out, err_out,
                             rd_addr_out, wr_addr_out}), 32'd0);
      chk("t6_rst_lr", 32'(gd_lr_out), 32'd0);
      chk("t6_reads_before", 32'(n_rd), 32'd2);
      tick(2);
      rst = 1'b0;
      tick(3);
      n_wr = 0;
      stray_req = 1'b1;
      tick(3);
      chk("t6_err_set", 32'(err_out), 32'd1);
      chk("t6_stray_no_write", 32'(n_wr), 32'd0);
      fill(11);
      launch(5'd2, 16'h0020, 1'b0);
      chk("t6_err_cleared", 32'(err_out), 32'd0);
      wait_done(50);
      chk("t6_done", 32'(t_done), 32'd7);
      chk("t6_writes", 32'(n_wr), 32'd2);
      chk("t6_err_after", 32'(err_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
